// File: rtl/painterengine_gpu_dma_reader.sv
`default_nettype none
// ============================================================================
// Module      : painterengine_gpu_dma_reader
// Description : Read-DMA engine for the GPU memcpy sequencer. Splits a
//               (address, length) request into AXI4 INCR read bursts that
//               never cross BOUNDARY_BYTES, forwards each returned word to
//               the copy FIFO and reports done / error as levels.
// Revision    : 1.0 - initial release
// ============================================================================
module painterengine_gpu_dma_reader #(
    parameter int MAX_BURST_BEATS = 16,
    parameter int BOUNDARY_BYTES  = 4096
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_reset,
    input  logic        i_wire_enable,
    input  logic [31:0] i_wire_address,
    input  logic [31:0] i_wire_length,
    output logic        o_wire_done,
    output logic        o_wire_error,
    output logic        o_wire_fifo_write,
    output logic [31:0] o_wire_fifo_data,
    input  logic        i_wire_fifo_full,
    output logic [31:0] o_wire_axi_araddr,
    output logic [7:0]  o_wire_axi_arlen,
    output logic [2:0]  o_wire_axi_arsize,
    output logic [1:0]  o_wire_axi_arburst,
    output logic        o_wire_axi_arvalid,
    input  logic        i_wire_axi_arready,
    input  logic [31:0] i_wire_axi_rdata,
    input  logic [1:0]  i_wire_axi_rresp,
    input  logic        i_wire_axi_rlast,
    input  logic        i_wire_axi_rvalid,
    output logic        o_wire_axi_rready,
    output logic [31:0] o_wire_state
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CHECK = 3'd1;
    localparam logic [2:0] c_ADDR  = 3'd2;
    localparam logic [2:0] c_DATA  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;
    localparam logic [2:0] c_ERROR = 3'd6;

    localparam logic [31:0] c_MAX_BEATS = 32'(MAX_BURST_BEATS);
    localparam logic [31:0] c_BOUNDARY  = 32'(BOUNDARY_BYTES);
    localparam logic [31:0] c_BMASK     = c_BOUNDARY - 32'd1;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q;      // address of the next beat to be fetched
    logic [31:0] remain_q;    // bytes still to be fetched
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic [8:0]  cnt_q;       // beats outstanding in the current burst
    logic        first_q;     // parameters not yet validated for this run
    logic        err_q;       // drain must end in ERROR rather than IDLE

    logic [31:0] w_words_left;
    logic [31:0] w_words_to_bound;
    logic [31:0] w_beats;
    logic [31:0] w_beats_m1;
    logic        w_bad_params;
    logic        w_rready;
    logic        w_beat;
    logic        w_cnt_last;
    logic        w_term;
    logic        w_beat_bad;
    logic        w_unused;

    // ------------------------------------------------------------------
    // Burst sizing: smallest of words left, max burst, words to boundary
    // ------------------------------------------------------------------
    assign w_words_left     = remain_q >> 2;
    assign w_words_to_bound = (c_BOUNDARY - (addr_q & c_BMASK)) >> 2;
    assign w_beats_m1       = w_beats - 32'd1;

    // Minimum of the three burst limits
    always_comb begin
        w_beats = w_words_left;
        if (c_MAX_BEATS < w_beats) begin
            w_beats = c_MAX_BEATS;
        end
        if (w_words_to_bound < w_beats) begin
            w_beats = w_words_to_bound;
        end
    end

    // Upper bits are always zero because a burst is at most 256 beats
    assign w_unused = ^{w_beats[31:9], w_beats_m1[31:8]};

    // Validation happens only on the first pass through CHECK
    assign w_bad_params = first_q &&
                          ((remain_q == 32'd0) || (remain_q[1:0] != 2'b00) ||
                           (addr_q[1:0] != 2'b00));

    // ------------------------------------------------------------------
    // Read-data beat qualification
    // ------------------------------------------------------------------
    assign w_beat     = i_wire_axi_rvalid && w_rready;
    assign w_cnt_last = (cnt_q == 9'd1);
    assign w_term     = i_wire_axi_rlast || w_cnt_last;
    assign w_beat_bad = (i_wire_axi_rresp != 2'b00) || (i_wire_axi_rlast != w_cnt_last);

    // State register
    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (i_wire_enable) begin
                    state_d = c_CHECK;
                end
            end
            c_CHECK: begin
                if (!i_wire_enable) begin
                    state_d = c_IDLE;
                end else if (w_bad_params) begin
                    state_d = c_ERROR;
                end else begin
                    state_d = c_ADDR;
                end
            end
            c_ADDR: begin
                // The address phase must complete even if enable falls
                if (i_wire_axi_arready) begin
                    state_d = i_wire_enable ? c_DATA : c_DRAIN;
                end
            end
            c_DATA: begin
                if (!i_wire_enable) begin
                    // Abort: the rest of the burst is swallowed silently
                    if (w_beat && w_term) begin
                        state_d = c_IDLE;
                    end else begin
                        state_d = c_DRAIN;
                    end
                end else if (w_beat) begin
                    if (w_beat_bad) begin
                        state_d = w_term ? c_ERROR : c_DRAIN;
                    end else if (w_cnt_last) begin
                        state_d = (remain_q == 32'd4) ? c_DONE : c_CHECK;
                    end
                end
            end
            c_DRAIN: begin
                if (w_beat && w_term) begin
                    state_d = err_q ? c_ERROR : c_IDLE;
                end
            end
            c_DONE, c_ERROR: begin
                if (!i_wire_enable) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_rready           = 1'b0;
        o_wire_fifo_write  = 1'b0;
        o_wire_axi_arvalid = (state_q == c_ADDR);
        o_wire_done        = (state_q == c_DONE);
        o_wire_error       = (state_q == c_ERROR);
        case (state_q)
            c_DATA: begin
                w_rready          = i_wire_enable ? !i_wire_fifo_full : 1'b1;
                o_wire_fifo_write = i_wire_enable && w_beat &&
                                    (i_wire_axi_rresp == 2'b00);
            end
            c_DRAIN: begin
                w_rready = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_wire_axi_rready  = w_rready;
    assign o_wire_fifo_data   = i_wire_axi_rdata;
    assign o_wire_axi_araddr  = araddr_q;
    assign o_wire_axi_arlen   = arlen_q;
    assign o_wire_axi_arsize  = 3'b010;
    assign o_wire_axi_arburst = 2'b01;
    assign o_wire_state       = {29'd0, state_q};

    // Datapath: request latch, burst setup and per-beat bookkeeping
    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            addr_q   <= 32'd0;
            remain_q <= 32'd0;
            araddr_q <= 32'd0;
            arlen_q  <= 8'd0;
            cnt_q    <= 9'd0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                c_IDLE: begin
                    err_q <= 1'b0;
                    if (i_wire_enable) begin
                        addr_q   <= i_wire_address;
                        remain_q <= i_wire_length;
                        first_q  <= 1'b1;
                    end
                end
                c_CHECK: begin
                    if (i_wire_enable && !w_bad_params) begin
                        araddr_q <= addr_q;
                        arlen_q  <= w_beats_m1[7:0];
                        cnt_q    <= w_beats[8:0];
                        first_q  <= 1'b0;
                    end
                end
                c_DATA: begin
                    if (w_beat) begin
                        cnt_q    <= cnt_q - 9'd1;
                        addr_q   <= addr_q + 32'd4;
                        remain_q <= remain_q - 32'd4;
                        if (i_wire_enable && w_beat_bad) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_beat) begin
                        cnt_q <= cnt_q - 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_painterengine_gpu_dma_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_painterengine_gpu_dma_reader
// Description : Directed bench with an AXI read-slave model and a FIFO-data
//               scoreboard for painterengine_gpu_dma_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_painterengine_gpu_dma_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] address;
    logic [31:0] length;
    logic        done;
    logic        error;
    logic        fifo_write;
    logic [31:0] fifo_data;
    logic        fifo_full;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] state;

    int errors = 0;
    int checks = 0;

    // Scoreboards: expected FIFO words and expected address phases
    logic [31:0] exp_q[$];
    logic [31:0] exp_ar_addr[$];
    logic [7:0]  exp_ar_len[$];

    // Slave model state
    logic [31:0] bq_addr[$];
    int          bq_len[$];
    int          bidx = 0;
    int          gbeat = 0;
    int          err_beat = -1;
    int          ar_delay = 0;
    int          ar_cnt = 0;

    // Handshakes observed at the negative edge, consumed after the next posedge
    logic        ar_hs = 1'b0;
    logic        r_hs = 1'b0;
    logic [31:0] hs_addr;
    logic [7:0]  hs_len;
    int          wr_count = 0;
    int          arv_cycles = 0;

    painterengine_gpu_dma_reader #(
        .MAX_BURST_BEATS(16),
        .BOUNDARY_BYTES (4096)
    ) dut (
        .i_wire_clock      (clk),
        .i_wire_reset      (rst),
        .i_wire_enable     (enable),
        .i_wire_address    (address),
        .i_wire_length     (length),
        .o_wire_done       (done),
        .o_wire_error      (error),
        .o_wire_fifo_write (fifo_write),
        .o_wire_fifo_data  (fifo_data),
        .i_wire_fifo_full  (fifo_full),
        .o_wire_axi_araddr (araddr),
        .o_wire_axi_arlen  (arlen),
        .o_wire_axi_arsize (arsize),
        .o_wire_axi_arburst(arburst),
        .o_wire_axi_arvalid(arvalid),
        .i_wire_axi_arready(arready),
        .i_wire_axi_rdata  (rdata),
        .i_wire_axi_rresp  (rresp),
        .i_wire_axi_rlast  (rlast),
        .i_wire_axi_rvalid (rvalid),
        .o_wire_axi_rready (rready),
        .o_wire_state      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: handshakes, FIFO scoreboard, done/error exclusivity
    initial begin
        forever begin
            @(negedge clk);
            ar_hs = 1'b0;
            r_hs  = 1'b0;
            if (!rst) begin
                ar_hs = arvalid && arready;
                r_hs  = rvalid && rready;
                if (arvalid) arv_cycles++;
                if (ar_hs) begin
                    hs_addr = araddr;
                    hs_len  = arlen;
                    chk("ar_expected", 32'(exp_ar_addr.size() != 0), 32'd1);
                    if (exp_ar_addr.size() != 0) begin
                        chk("araddr", araddr, exp_ar_addr.pop_front());
                        chk("arlen", 32'(arlen), 32'(exp_ar_len.pop_front()));
                    end
                end
                if (fifo_write) begin
                    wr_count++;
                    chk("fifo_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        chk("fifo_data", fifo_data, exp_q.pop_front());
                    end
                end
                chk("done_error_exclusive", 32'(done && error), 32'd0);
            end
        end
    end

    // AXI read slave: drives right after each rising edge
    initial begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (ar_hs) begin
                bq_addr.push_back(hs_addr);
                bq_len.push_back(int'(hs_len) + 1);
                ar_cnt = 0;
            end
            if (r_hs) begin
                gbeat++;
                bidx++;
                if (bidx == bq_len[0]) begin
                    void'(bq_addr.pop_front());
                    void'(bq_len.pop_front());
                    bidx = 0;
                end
            end
            if (arvalid && !rst) begin
                arready = (ar_cnt >= ar_delay);
                ar_cnt++;
            end else begin
                arready = 1'b0;
            end
            if (bq_addr.size() != 0) begin
                rvalid = 1'b1;
                rdata  = fdat(bq_addr[0] + 32'(4 * bidx));
                rlast  = (bidx == bq_len[0] - 1);
                rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'd0;
            end
        end
    end

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        exp_ar_addr.push_back(a);
        exp_ar_len.push_back(l);
    endtask

    task automatic push_words(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(fdat(a + 32'(4 * i)));
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] l);
        address = a;
        length  = l;
        enable  = 1'b1;
    endtask

    // Waits (bounded) until the state code is seen at a negative edge
    task automatic wait_state(input logic [31:0] code, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state !== code && n < budget);
        chk("wait_state", state, code);
    endtask

    // Waits (bounded) until the write count reaches target; returns after posedge+1
    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (wr_count < target && n < budget);
        chk("wait_writes", 32'(wr_count), 32'(target));
    endtask

    // Drops enable and confirms the return to IDLE with both flags clear
    task automatic finish_xfer(input string tag);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle_state"}, state, 32'd0);
        chk({tag, "_idle_flags"}, {30'd0, done, error}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        int a0;
        logic [31:0] bad_addr [3];
        logic [31:0] bad_len  [3];
        bad_addr[0] = 32'h0000_1000; bad_len[0] = 32'd6;
        bad_addr[1] = 32'h0000_1002; bad_len[1] = 32'd16;
        bad_addr[2] = 32'h0000_1000; bad_len[2] = 32'd0;

        rst = 1'b1; enable = 1'b0; address = 32'd0; length = 32'd0; fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", state, 32'd0);
        chk("rst_flags", {27'd0, done, error, arvalid, rready, fifo_write}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arlen", 32'(arlen), 32'd0);
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single 4-beat burst
        push_ar(32'h1000, 8'd3);
        push_words(32'h1000, 4);
        w0 = wr_count;
        start(32'h1000, 32'd16);
        wait_writes(w0 + 4, 100);
        @(negedge clk);
        chk("t1_done_next_cycle", 32'(done), 32'd1);
        chk("t1_state", state, 32'd5);
        @(posedge clk);
        #1;
        chk("t1_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_ar_empty", 32'(exp_ar_addr.size()), 32'd0);
        finish_xfer("t1");

        // Boundary crossing, three bursts
        push_ar(32'h0FF8, 8'd1);
        push_ar(32'h1000, 8'd15);
        push_ar(32'h1040, 8'd5);
        push_words(32'h0FF8, 24);
        w0 = wr_count;
        start(32'h0FF8, 32'd96);
        wait_state(32'd5, 400);
        chk("t2_done", {30'd0, done, error}, 32'd2);
        @(posedge clk);
        #1;
        chk("t2_writes", 32'(wr_count - w0), 32'd24);
        chk("t2_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("t2_ar_empty", 32'(exp_ar_addr.size()), 32'd0);
        finish_xfer("t2");

        // Illegal parameters: error two cycles after enable, no address phase
        for (int k = 0; k < 3; k++) begin
            a0 = arv_cycles;
            start(bad_addr[k], bad_len[k]);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk("t3_error", {30'd0, done, error}, 32'd1);
            chk("t3_state", state, 32'd6);
            finish_xfer("t3");
            chk("t3_no_arvalid", 32'(arv_cycles - a0), 32'd0);
        end

        // Slave error on the third beat
        gbeat = 0;
        err_beat = 2;
        push_ar(32'h2000, 8'd7);
        push_words(32'h2000, 2);
        w0 = wr_count;
        start(32'h2000, 32'd32);
        wait_state(32'd6, 200);
        chk("t4_error", {30'd0, done, error}, 32'd1);
        @(posedge clk);
        #1;
        chk("t4_writes", 32'(wr_count - w0), 32'd2);
        chk("t4_drained", 32'(bq_addr.size()), 32'd0);
        chk("t4_exp_empty", 32'(exp_q.size()), 32'd0);
        err_beat = -1;
        finish_xfer("t4");

        // FIFO back-pressure mid-burst
        push_ar(32'h3000, 8'd7);
        push_words(32'h3000, 8);
        w0 = wr_count;
        start(32'h3000, 32'd32);
        wait_writes(w0 + 3, 100);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_rready_low", {30'd0, rready, fifo_write}, 32'd0);
            @(posedge clk);
            #1;
        end
        fifo_full = 1'b0;
        wait_state(32'd5, 100);
        @(posedge clk);
        #1;
        chk("t5_writes", 32'(wr_count - w0), 32'd8);
        chk("t5_exp_empty", 32'(exp_q.size()), 32'd0);
        finish_xfer("t5");

        // Enable dropped during a stalled address phase
        ar_delay = 6;
        push_ar(32'h1000, 8'd3);
        w0 = wr_count;
        start(32'h1000, 32'd16);
        wait_state(32'd2, 20);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(negedge clk);
        chk("t6_arvalid_held", {30'd0, arvalid, arready}, 32'd2);
        wait_state(32'd0, 100);
        chk("t6_flags", {30'd0, done, error}, 32'd0);
        @(posedge clk);
        #1;
        chk("t6_no_writes", 32'(wr_count - w0), 32'd0);
        chk("t6_ar_seen", 32'(exp_ar_addr.size()), 32'd0);
        chk("t6_drained", 32'(bq_addr.size()), 32'd0);
        ar_delay = 0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
